camera_capture_sequencer: RTL and testbench
===========================================

Name: camera_capture_sequencer

Overview:
N-channel generalisation of the camera capture controller. Arms one camera-link channel per frame and tracks frame start, capture end and DMA drain, with a timeout watchdog. Muxes the active channel's pixel stream toward the DMA writer. Adds a round-robin scan mode over an enable mask, lock-loss abort, an explicit abort and sticky status.

Parameters:
NUM_CH, 4, number of camera channels (2..16)
SEL_W, $clog2(NUM_CH), channel index width
DATA_W, 64, pixel word width per channel
TO_W, 32, timeout counter width
FCNT_W, 16, completed-frame counter width

Ports:
sys_clk  in  1  system clock; all logic is synchronous to it
sys_rst_n  in  1  reset, asynchronous assert, active-low
mode  in  1  0 = single capture, 1 = round-robin scan
ch_sel  in  SEL_W  channel used in single mode
ch_enable_mask  in  NUM_CH  channels included in scan mode
start  in  1  pulse; requests a capture
abort  in  1  pulse; forces return to IDLE
status_clr  in  1  clears the sticky status bits
timeout  in  TO_W  cycle limit per capture; 0 disables the watchdog
drain_done  in  1  DMA accepted the final beat (tlast & tready)
ch_locked  in  NUM_CH  per-channel serdes lock
ch_new_frame  in  NUM_CH  per-channel frame-start pulse
ch_capture_end  in  NUM_CH  per-channel capture-complete pulse
ch_vld  in  NUM_CH  per-channel pixel valid
ch_data  in  NUM_CH*DATA_W  pixel words; channel k occupies [k*DATA_W +: DATA_W]
ch_arm  out  NUM_CH  one-hot, one-cycle capture request to the selected camera controller
active_ch  out  SEL_W  currently selected channel
camera_in_progress  out  1  high whenever state != IDLE
serde_locked  out  1  ch_locked[active_ch]
frame_rst  out  1  one-cycle pulse on the accepted frame start
out_data  out  DATA_W  registered data of the active channel
out_vld  out  1  registered valid
out_end  out  1  registered capture-end pulse
frame_count  out  FCNT_W  completed frames; wraps
status_timeout  out  1  sticky; set when the watchdog fires
status_lockloss  out  1  sticky; set on lock loss or on a start to an unlocked channel

Behaviour:
- Reset: state = IDLE; all outputs and counters = 0.
- States:
  - IDLE: waiting for start.
  - WAIT_FRAME: channel armed, waiting for its frame start.
  - CAPTURE: pixels flowing.
  - DRAIN: waiting for the DMA to finish.
- IDLE, start=1:
  - Channel choice. Single mode uses ch_sel; a start with ch_sel >= NUM_CH is ignored. Scan mode uses the lowest set bit of ch_enable_mask; a start with mask = 0 is ignored.
  - If the chosen channel is unlocked: start is ignored and status_lockloss is set.
  - Otherwise: active_ch latches the chosen channel, ch_arm[active_ch] pulses the following cycle, and state -> WAIT_FRAME.
- start in any state other than IDLE is ignored.
- WAIT_FRAME, ch_new_frame[active_ch]=1: frame_rst pulses the next cycle; state -> CAPTURE.
- CAPTURE:
  - out_vld <= ch_vld[active_ch] and out_data <= the active channel's word (1-cycle latency).
  - out_vld = 0 in every other state; out_data holds its last value.
- CAPTURE, ch_capture_end[active_ch]=1: out_end pulses with 1-cycle latency; state -> DRAIN. A valid beat in the same cycle is still forwarded.
- DRAIN, drain_done=1:
  - frame_count increments (wraps).
  - Single mode: -> IDLE.
  - Scan mode: the next set mask bit above active_ch, wrapping, becomes active_ch. ch_arm pulses and state -> WAIT_FRAME. The mask is sampled at this moment; if it is now 0 -> IDLE.
- Watchdog:
  - Counter clears in IDLE and on every scan re-arm; otherwise it increments each cycle.
  - When counter == timeout and timeout != 0: -> IDLE and status_timeout is set.
- Lock loss: ch_locked[active_ch]=0 in WAIT_FRAME or CAPTURE -> IDLE and status_lockloss is set. A lock drop in DRAIN is ignored, because data is already in the DMA path.
- Priority in the same cycle: abort > lock loss > timeout > normal transition. An abort on the drain_done cycle returns to IDLE without incrementing frame_count.
- ch_* events on non-active channels are ignored. ch_sel and mode are sampled only when a capture starts.
- status_clr clears both sticky bits. If set and clear occur in the same cycle, set wins.
- Asserting sys_rst_n low mid-capture immediately restores the reset values.

Test Plan:
- Single mode, NUM_CH=4, ch_sel=2, locked. Pulse start, then new_frame[2], then 8 vld beats, then capture_end[2], then drain_done -> ch_arm=4'b0100 for 1 cycle; frame_rst 1 pulse; 8 out_vld beats, each 1 cycle late with matching data; frame_count=1; back to IDLE.
- Scan mode with mask=4'b1010, running 3 frames -> active_ch sequence 1, 3, 1; frame_count=3; ch_arm pulses 0010, 1000, 0010.
- timeout=100 with no new_frame -> returns to IDLE on cycle 100 after arm; status_timeout=1; status_clr brings it to 0.
- ch_locked[active] drops in CAPTURE -> IDLE next cycle, status_lockloss=1, out_vld=0; a start to an unlocked channel is ignored with status_lockloss=1.
- abort and drain_done in the same cycle -> IDLE, frame_count unchanged.
- Events and vld on non-active channels during CAPTURE -> no out_vld, no state change; sys_rst_n pulsed mid-CAPTURE -> all outputs 0.

Source files
------------

// File: rtl/camera_capture_sequencer_if.sv
// Control, per-channel camera-link and DMA-side signals of the capture sequencer.
// master = host/camera side, slave = sequencer.
interface camera_capture_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int DATA_W = 64,
  parameter int TO_W   = 32,
  parameter int FCNT_W = 16
);
  logic                     mode;
  logic [SEL_W-1:0]         ch_sel;
  logic [NUM_CH-1:0]        ch_enable_mask;
  logic                     start;
  logic                     abort;
  logic                     status_clr;
  logic [TO_W-1:0]          timeout;
  logic                     drain_done;
  logic [NUM_CH-1:0]        ch_locked;
  logic [NUM_CH-1:0]        ch_new_frame;
  logic [NUM_CH-1:0]        ch_capture_end;
  logic [NUM_CH-1:0]        ch_vld;
  logic [NUM_CH*DATA_W-1:0] ch_data;

  logic [NUM_CH-1:0]        ch_arm;
  logic [SEL_W-1:0]         active_ch;
  logic                     camera_in_progress;
  logic                     serde_locked;
  logic                     frame_rst;
  logic [DATA_W-1:0]        out_data;
  logic                     out_vld;
  logic                     out_end;
  logic [FCNT_W-1:0]        frame_count;
  logic                     status_timeout;
  logic                     status_lockloss;

  modport master (
    output mode, ch_sel, ch_enable_mask, start, abort, status_clr, timeout,
           drain_done, ch_locked, ch_new_frame, ch_capture_end, ch_vld, ch_data,
    input  ch_arm, active_ch, camera_in_progress, serde_locked, frame_rst,
           out_data, out_vld, out_end, frame_count, status_timeout, status_lockloss
  );

  modport slave (
    input  mode, ch_sel, ch_enable_mask, start, abort, status_clr, timeout,
           drain_done, ch_locked, ch_new_frame, ch_capture_end, ch_vld, ch_data,
    output ch_arm, active_ch, camera_in_progress, serde_locked, frame_rst,
           out_data, out_vld, out_end, frame_count, status_timeout, status_lockloss
  );
endinterface

// File: rtl/camera_capture_sequencer.sv
// N-channel capture sequencer: arms one camera channel per frame, muxes its pixels to DMA (1-cycle latency).
// No backpressure on pixels; drain completion is signalled by drain_done. Watchdog, lock-loss and abort return to IDLE.
module camera_capture_sequencer #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int DATA_W = 64,
  parameter int TO_W   = 32,
  parameter int FCNT_W = 16
) (
  input logic                       sys_clk,
  input logic                       sys_rst_n,
  camera_capture_sequencer_if.slave cam
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_FRAME, S_CAPTURE, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    active_q, active_d;
  logic                mode_q, mode_d;
  logic [TO_W-1:0]     wd_q, wd_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                st_to_q, st_to_d;
  logic                st_ll_q, st_ll_d;
  logic [NUM_CH-1:0]   arm_q, arm_d;
  logic                frame_rst_q, frame_rst_d;
  logic                out_vld_q, out_vld_d;
  logic                out_end_q, out_end_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;

  logic                sel_ok, low_ok, nxt_ok;
  logic [SEL_W-1:0]    low_idx, nxt_idx, start_idx;
  logic                start_ok, start_lock;
  logic                act_lock, act_frame, act_end, act_vld;
  logic [DATA_W-1:0]   act_data;
  logic                lock_lost, to_fire;
  logic                do_arm, frame_pulse, end_pulse, cap_ok, set_to, set_ll;

  // Channel choice: validated ch_sel, lowest mask bit, and next mask bit above active (wrapping).
  always_comb begin
    int idx;
    idx     = 0;
    sel_ok  = 1'b0;
    low_ok  = 1'b0;
    low_idx = '0;
    nxt_ok  = 1'b0;
    nxt_idx = active_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cam.ch_sel == SEL_W'(k)) sel_ok = 1'b1;
    end
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (cam.ch_enable_mask[k]) begin
        low_idx = SEL_W'(k);
        low_ok  = 1'b1;
      end
    end
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(active_q) + i) % NUM_CH;
      if (cam.ch_enable_mask[idx[SEL_W-1:0]]) begin
        nxt_idx = idx[SEL_W-1:0];
        nxt_ok  = 1'b1;
      end
    end
  end

  assign start_idx  = cam.mode ? low_idx : cam.ch_sel;
  assign start_ok   = cam.mode ? low_ok : sel_ok;
  assign start_lock = cam.ch_locked[start_idx];

  assign act_lock  = cam.ch_locked[active_q];
  assign act_frame = cam.ch_new_frame[active_q];
  assign act_end   = cam.ch_capture_end[active_q];
  assign act_vld   = cam.ch_vld[active_q];
  assign act_data  = cam.ch_data[active_q*DATA_W +: DATA_W];

  assign lock_lost = ((state_q == S_WAIT_FRAME) || (state_q == S_CAPTURE)) && !act_lock;
  assign to_fire   = (state_q != S_IDLE) && (cam.timeout != '0) && (wd_q == cam.timeout);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      active_q    <= '0;
      mode_q      <= 1'b0;
      wd_q        <= '0;
      fcnt_q      <= '0;
      st_to_q     <= 1'b0;
      st_ll_q     <= 1'b0;
      arm_q       <= '0;
      frame_rst_q <= 1'b0;
      out_vld_q   <= 1'b0;
      out_end_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      mode_q      <= mode_d;
      wd_q        <= wd_d;
      fcnt_q      <= fcnt_d;
      st_to_q     <= st_to_d;
      st_ll_q     <= st_ll_d;
      arm_q       <= arm_d;
      frame_rst_q <= frame_rst_d;
      out_vld_q   <= out_vld_d;
      out_end_q   <= out_end_d;
      out_data_q  <= out_data_d;
    end
  end

  // Next state; abort > lock loss > timeout > normal progress.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    mode_d      = mode_q;
    wd_d        = (state_q == S_IDLE) ? '0 : wd_q + 1'b1;
    fcnt_d      = fcnt_q;
    do_arm      = 1'b0;
    frame_pulse = 1'b0;
    end_pulse   = 1'b0;
    cap_ok      = 1'b0;
    set_to      = 1'b0;
    set_ll      = 1'b0;
    if (cam.abort) begin
      state_d = S_IDLE;
    end else if (lock_lost) begin
      state_d = S_IDLE;
      set_ll  = 1'b1;
    end else if (to_fire) begin
      state_d = S_IDLE;
      set_to  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cam.start && start_ok) begin
            if (!start_lock) begin
              set_ll = 1'b1;
            end else begin
              active_d = start_idx;
              mode_d   = cam.mode;
              do_arm   = 1'b1;
              state_d  = S_WAIT_FRAME;
            end
          end
        end
        S_WAIT_FRAME: begin
          if (act_frame) begin
            frame_pulse = 1'b1;
            state_d     = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          cap_ok = 1'b1;
          if (act_end) begin
            end_pulse = 1'b1;
            state_d   = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cam.drain_done) begin
            fcnt_d = fcnt_q + 1'b1;
            if (mode_q && nxt_ok) begin
              active_d = nxt_idx;
              do_arm   = 1'b1;
              wd_d     = '0;
              state_d  = S_WAIT_FRAME;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs and sticky status; a set in the same cycle as a clear wins.
  always_comb begin
    arm_d       = do_arm ? (NUM_CH'(1) << active_d) : '0;
    frame_rst_d = frame_pulse;
    out_end_d   = end_pulse;
    out_vld_d   = cap_ok && act_vld;
    out_data_d  = cap_ok ? act_data : out_data_q;
    st_to_d     = set_to | (st_to_q & ~cam.status_clr);
    st_ll_d     = set_ll | (st_ll_q & ~cam.status_clr);
  end

  assign cam.ch_arm             = arm_q;
  assign cam.active_ch          = active_q;
  assign cam.camera_in_progress = (state_q != S_IDLE);
  assign cam.serde_locked       = act_lock;
  assign cam.frame_rst          = frame_rst_q;
  assign cam.out_data           = out_data_q;
  assign cam.out_vld            = out_vld_q;
  assign cam.out_end            = out_end_q;
  assign cam.frame_count        = fcnt_q;
  assign cam.status_timeout     = st_to_q;
  assign cam.status_lockloss    = st_ll_q;

endmodule

// File: tb/tb_camera_capture_sequencer.sv
// Scoreboard bench for camera_capture_sequencer: expected pixel beats and arm patterns are queued when
// driven and popped by a negedge monitor; control outcomes are checked #1 after the clock edge.
module tb_camera_capture_sequencer;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 64;

  typedef struct {
    logic [DATA_W-1:0] d;
    int                due;
  } beat_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc_n = 0;
  int   arm_cnt = 0;
  int   frst_cnt = 0;
  int   beat_cnt = 0;
  int   exp_fcnt = 0;
  beat_t              exp_q[$];
  logic [NUM_CH-1:0]  arm_exp_q[$];

  camera_capture_sequencer_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DATA_W(DATA_W)) cam ();

  camera_capture_sequencer #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .cam      (cam)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sys_rst_n && cam.out_vld) begin
      beat_cnt++;
      if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", cam.out_data, e.d);
        chk("beat_cycle", 64'(cyc_n), 64'(e.due));
      end
    end
    if (sys_rst_n && cam.ch_arm != '0) begin
      arm_cnt++;
      if (arm_exp_q.size() == 0) chk("arm_unexpected", 64'(cam.ch_arm), 0);
      else chk("arm_pattern", 64'(cam.ch_arm), 64'(arm_exp_q.pop_front()));
    end
    if (sys_rst_n && cam.frame_rst) frst_cnt++;
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start(input logic m, input int sel);
    cam.mode = m;
    cam.ch_sel = SEL_W'(sel);
    cam.start = 1'b1;
    cyc();
    cam.start = 1'b0;
  endtask

  // From WAIT_FRAME on channel ch: frame start, nb beats, capture end, drain.
  task automatic run_frame(input int ch, input int nb);
    beat_t e;
    cam.ch_new_frame[ch] = 1'b1;
    cyc();
    cam.ch_new_frame = '0;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < NUM_CH; k++) cam.ch_data[k*DATA_W +: DATA_W] = {$urandom, $urandom};
      cam.ch_vld = 4'b1111;
      e.d = cam.ch_data[ch*DATA_W +: DATA_W];
      e.due = cyc_n + 1;
      exp_q.push_back(e);
      cyc();
    end
    cam.ch_vld = '0;
    cam.ch_capture_end[ch] = 1'b1;
    cyc();
    cam.ch_capture_end = '0;
    chk("out_end", cam.out_end, 1);
    cam.drain_done = 1'b1;
    cyc();
    cam.drain_done = 1'b0;
    exp_fcnt++;
    chk("frame_count", cam.frame_count, 64'(exp_fcnt));
  endtask

  initial begin
    int n;
    cam.mode = 0; cam.ch_sel = '0; cam.ch_enable_mask = '0; cam.start = 0; cam.abort = 0;
    cam.status_clr = 0; cam.timeout = '0; cam.drain_done = 0; cam.ch_locked = '1;
    cam.ch_new_frame = '0; cam.ch_capture_end = '0; cam.ch_vld = '0; cam.ch_data = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_in_progress", cam.camera_in_progress, 0);
    chk("rst_arm", 64'(cam.ch_arm), 0);
    chk("rst_active", 64'(cam.active_ch), 0);
    chk("rst_fcnt", cam.frame_count, 0);
    chk("rst_out_vld", cam.out_vld, 0);
    chk("rst_status", {cam.status_timeout, cam.status_lockloss}, 0);
    sys_rst_n = 1'b1;
    cyc();

    // Single capture on channel 2
    arm_exp_q.push_back(4'b0100);
    pulse_start(0, 2);
    chk("single_in_progress", cam.camera_in_progress, 1);
    chk("single_active", 64'(cam.active_ch), 2);
    run_frame(2, 8);
    chk("single_idle", cam.camera_in_progress, 0);
    cyc();
    chk("single_arm_cnt", 64'(arm_cnt), 1);
    chk("single_frst_cnt", 64'(frst_cnt), 1);
    chk("single_beats", 64'(beat_cnt), 8);

    // Round-robin scan over mask 1010: channels 1, 3, 1
    cam.ch_enable_mask = 4'b1010;
    arm_exp_q.push_back(4'b0010);
    arm_exp_q.push_back(4'b1000);
    arm_exp_q.push_back(4'b0010);
    pulse_start(1, 0);
    chk("scan_active0", 64'(cam.active_ch), 1);
    run_frame(1, 2);
    chk("scan_active1", 64'(cam.active_ch), 3);
    chk("scan_still_busy", cam.camera_in_progress, 1);
    run_frame(3, 2);
    chk("scan_active2", 64'(cam.active_ch), 1);
    cam.ch_enable_mask = '0;
    run_frame(1, 1);
    chk("scan_mask0_idle", cam.camera_in_progress, 0);
    cyc();
    chk("scan_arm_cnt", 64'(arm_cnt), 4);

    // Watchdog
    cam.timeout = 100;
    arm_exp_q.push_back(4'b0010);
    pulse_start(0, 1);
    n = 0;
    while (cam.camera_in_progress && n < 200) begin
      cyc();
      n++;
    end
    chk("wd_in_window", (n >= 100 && n <= 101), 1);
    chk("wd_status", cam.status_timeout, 1);
    chk("wd_fcnt_same", cam.frame_count, 64'(exp_fcnt));
    cam.status_clr = 1'b1;
    cyc();
    cam.status_clr = 1'b0;
    chk("wd_status_clr", cam.status_timeout, 0);
    cam.timeout = '0;

    // Lock loss in CAPTURE, then start to an unlocked channel
    arm_exp_q.push_back(4'b0001);
    pulse_start(0, 0);
    cam.ch_new_frame[0] = 1'b1;
    cyc();
    cam.ch_new_frame = '0;
    cam.ch_vld[0] = 1'b1;
    cam.ch_locked[0] = 1'b0;
    cyc();
    cam.ch_vld = '0;
    chk("ll_idle", cam.camera_in_progress, 0);
    chk("ll_out_vld", cam.out_vld, 0);
    chk("ll_status", cam.status_lockloss, 1);
    cam.status_clr = 1'b1;
    cyc();
    cam.status_clr = 1'b0;
    chk("ll_clr", cam.status_lockloss, 0);
    pulse_start(0, 0);
    chk("ll_start_ignored", cam.camera_in_progress, 0);
    chk("ll_start_status", cam.status_lockloss, 1);
    cam.ch_locked = '1;
    cam.status_clr = 1'b1;
    cyc();
    cam.status_clr = 1'b0;

    // Abort coincident with drain_done
    arm_exp_q.push_back(4'b1000);
    pulse_start(0, 3);
    cam.ch_new_frame[3] = 1'b1;
    cyc();
    cam.ch_new_frame = '0;
    cam.ch_capture_end[3] = 1'b1;
    cyc();
    cam.ch_capture_end = '0;
    cam.abort = 1'b1;
    cam.drain_done = 1'b1;
    cyc();
    cam.abort = 1'b0;
    cam.drain_done = 1'b0;
    chk("abort_idle", cam.camera_in_progress, 0);
    chk("abort_fcnt", cam.frame_count, 64'(exp_fcnt));

    // Non-active channel events, then reset mid-capture
    arm_exp_q.push_back(4'b0100);
    pulse_start(0, 2);
    cam.ch_new_frame[2] = 1'b1;
    cyc();
    cam.ch_new_frame = '0;
    cam.ch_vld = 4'b1011;
    cam.ch_new_frame = 4'b1011;
    cam.ch_capture_end = 4'b1011;
    cam.ch_data = {4{64'hDEAD_BEEF_0000_0001}};
    cyc();
    cam.ch_vld = '0; cam.ch_new_frame = '0; cam.ch_capture_end = '0;
    chk("noise_out_vld", cam.out_vld, 0);
    chk("noise_out_end", cam.out_end, 0);
    chk("noise_busy", cam.camera_in_progress, 1);
    chk("noise_active", 64'(cam.active_ch), 2);
    begin
      beat_t e;
      cam.ch_data[2*DATA_W +: DATA_W] = 64'hA5A5_0000_1234_5678;
      cam.ch_vld[2] = 1'b1;
      e.d = 64'hA5A5_0000_1234_5678;
      e.due = cyc_n + 1;
      exp_q.push_back(e);
      cyc();
      cam.ch_vld = '0;
      cyc();
    end
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_busy", cam.camera_in_progress, 0);
    chk("arst_out_data", cam.out_data, 0);
    chk("arst_fcnt", cam.frame_count, 0);
    chk("arst_active", 64'(cam.active_ch), 0);
    chk("arst_vld_end", {cam.out_vld, cam.out_end, cam.frame_rst}, 0);
    #3 sys_rst_n = 1'b1;
    cyc();
    cyc();

    chk("beats_left", 64'(exp_q.size()), 0);
    chk("arms_left", 64'(arm_exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
